// File: rtl/cmd_decoder_fsm_if.sv
// Command/dispatch bundle between the scenario reader, cmd_decoder_fsm and the
// SET/WAIT/CHECK blocks. Each argument is ARG_W bits of right-aligned ASCII.
interface cmd_decoder_fsm_if #(
  parameter int ARGS_NB   = 5,
  parameter int ARG_W     = 64,
  parameter int TO_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
);
  logic [ARGS_NB-1:0][ARG_W-1:0] i_args;
  logic                          i_args_valid;
  logic [TO_WIDTH-1:0]           i_timeout;
  logic                          o_busy;
  logic                          o_sel_set;
  logic                          i_set_done;
  logic                          o_sel_wait;
  logic                          o_wait_edge;
  logic                          i_wait_done;
  logic                          o_sel_check;
  logic                          i_check_done;
  logic                          i_check_ok;
  logic                          o_ack;
  logic                          o_err;
  logic [1:0]                    o_err_code;
  logic [CNT_WIDTH-1:0]          o_cmd_cnt;

  modport slave (
    input  i_args, i_args_valid, i_timeout, i_set_done, i_wait_done,
           i_check_done, i_check_ok,
    output o_busy, o_sel_set, o_sel_wait, o_wait_edge, o_sel_check,
           o_ack, o_err, o_err_code, o_cmd_cnt
  );

  modport master (
    output i_args, i_args_valid, i_timeout, i_set_done, i_wait_done,
           i_check_done, i_check_ok,
    input  o_busy, o_sel_set, o_sel_wait, o_wait_edge, o_sel_check,
           o_ack, o_err, o_err_code, o_cmd_cnt
  );
endinterface

// File: rtl/cmd_decoder_fsm.sv
// Scenario command decoder: dispatches SET/WTR/WTF/CHK, tracks wait timeout, acks.
// Define CMD_DECODER_ERR_STICKY_EN to make o_err/o_err_code hold the first error.
module cmd_decoder_fsm #(
  parameter int ARGS_NB   = 5,
  parameter int ARG_W     = 64,
  parameter int TO_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cmd_decoder_fsm_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_SET, S_WAIT, S_CHECK, S_ACK, S_ERR
  } state_t;

  localparam logic [ARG_W-1:0] OP_SET = ARG_W'("SET");
  localparam logic [ARG_W-1:0] OP_WTR = ARG_W'("WTR");
  localparam logic [ARG_W-1:0] OP_WTF = ARG_W'("WTF");
  localparam logic [ARG_W-1:0] OP_CHK = ARG_W'("CHK");

  state_t              state, state_n;
  logic [ARG_W-1:0]    op_q;
  logic [TO_WIDTH-1:0] to_q;
  logic [TO_WIDTH-1:0] wait_cnt;
  logic [1:0]          code_n;
  logic                accept;

  // Only the opcode is decoded; the remaining arguments belong to the sub-blocks.
  logic unused_args;
  assign unused_args = ^bus.i_args[ARGS_NB-1:1];

  assign accept = (state == S_IDLE) && bus.i_args_valid;

  always_comb begin
    state_n = state;
    code_n  = 2'd0;
    unique case (state)
      S_IDLE:   if (bus.i_args_valid) state_n = S_DECODE;
      S_DECODE: begin
        if (op_q == OP_SET)                        state_n = S_SET;
        else if (op_q == OP_WTR || op_q == OP_WTF) state_n = S_WAIT;
        else if (op_q == OP_CHK)                   state_n = S_CHECK;
        else begin
          state_n = S_ERR;
          code_n  = 2'd1;
        end
      end
      S_SET:    if (bus.i_set_done) state_n = S_ACK;
      S_WAIT: begin
        // done has priority over a timeout landing in the same cycle
        if (bus.i_wait_done) state_n = S_ACK;
        else if (to_q != '0 && wait_cnt == to_q - TO_WIDTH'(1)) begin
          state_n = S_ERR;
          code_n  = 2'd2;
        end
      end
      S_CHECK: begin
        if (bus.i_check_done) begin
          if (bus.i_check_ok) state_n = S_ACK;
          else begin
            state_n = S_ERR;
            code_n  = 2'd3;
          end
        end
      end
      S_ACK, S_ERR: state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      op_q            <= '0;
      to_q            <= '0;
      wait_cnt        <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_sel_set   <= 1'b0;
      bus.o_sel_wait  <= 1'b0;
      bus.o_wait_edge <= 1'b0;
      bus.o_sel_check <= 1'b0;
      bus.o_ack       <= 1'b0;
      bus.o_err       <= 1'b0;
      bus.o_err_code  <= 2'd0;
      bus.o_cmd_cnt   <= '0;
    end else begin
      state           <= state_n;
      bus.o_busy      <= (state_n != S_IDLE);
      bus.o_sel_set   <= (state_n == S_SET);
      bus.o_sel_wait  <= (state_n == S_WAIT);
      bus.o_wait_edge <= (state_n == S_WAIT) && (op_q == OP_WTF);
      bus.o_sel_check <= (state_n == S_CHECK);
      bus.o_ack       <= (state_n == S_ACK) || (state_n == S_ERR);

      if (accept) begin
        op_q <= bus.i_args[0];
        to_q <= bus.i_timeout;
      end

      wait_cnt <= (state == S_WAIT) ? wait_cnt + TO_WIDTH'(1) : '0;

      if (state_n == S_ACK || state_n == S_ERR)
        bus.o_cmd_cnt <= bus.o_cmd_cnt + CNT_WIDTH'(1);

`ifdef CMD_DECODER_ERR_STICKY_EN
      if (state_n == S_ERR && !bus.o_err) begin
        bus.o_err      <= 1'b1;
        bus.o_err_code <= code_n;
      end
`else
      bus.o_err <= (state_n == S_ERR);
      if (accept)
        bus.o_err_code <= 2'd0;
      else if (state_n == S_ERR)
        bus.o_err_code <= code_n;
`endif
    end
  end
endmodule

// File: tb/tb_cmd_decoder_fsm.sv
// Bench for cmd_decoder_fsm: command table with ack scoreboard, mid-WAIT reset
// and counter wrap on a CNT_WIDTH=2 twin instance.
module tb_cmd_decoder_fsm;
  localparam int ARGS_NB = 5;
  localparam int ARG_W   = 64;
  localparam int TO_W    = 16;
  localparam int CNT_W   = 16;

  localparam logic [ARG_W-1:0] OP_SET = ARG_W'("SET");
  localparam logic [ARG_W-1:0] OP_WTR = ARG_W'("WTR");
  localparam logic [ARG_W-1:0] OP_WTF = ARG_W'("WTF");
  localparam logic [ARG_W-1:0] OP_CHK = ARG_W'("CHK");
  localparam logic [ARG_W-1:0] OP_XYZ = ARG_W'("XYZ");

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_decoder_fsm_if #(.ARGS_NB(ARGS_NB), .ARG_W(ARG_W), .TO_WIDTH(TO_W), .CNT_WIDTH(CNT_W)) bus ();
  cmd_decoder_fsm_if #(.ARGS_NB(ARGS_NB), .ARG_W(ARG_W), .TO_WIDTH(TO_W), .CNT_WIDTH(2)) bus2 ();

  cmd_decoder_fsm #(.ARGS_NB(ARGS_NB), .ARG_W(ARG_W), .TO_WIDTH(TO_W), .CNT_WIDTH(CNT_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  cmd_decoder_fsm #(.ARGS_NB(ARGS_NB), .ARG_W(ARG_W), .TO_WIDTH(TO_W), .CNT_WIDTH(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.i_args       = bus.i_args;
  assign bus2.i_args_valid = bus.i_args_valid;
  assign bus2.i_timeout    = bus.i_timeout;
  assign bus2.i_set_done   = bus.i_set_done;
  assign bus2.i_wait_done  = bus.i_wait_done;
  assign bus2.i_check_done = bus.i_check_done;
  assign bus2.i_check_ok   = bus.i_check_ok;

  typedef struct {
    logic [ARG_W-1:0] op;
    int               to;
    logic             set_done, chk_done, chk_ok;
    int               wd_at;    // WAIT cycle index from which done is high (-1 never)
    int               poke_at;  // WAIT cycle index for a stray valid pulse (-1 none)
    int               exp_sel;
    int               exp_lat;
    logic [1:0]       code;
  } vec_t;

  typedef struct packed { logic err; logic [1:0] code; } exp_t;

  exp_t sb[$];
  exp_t last_e;
  logic sticky_err;
  logic [1:0] sticky_code;
  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [ARG_W-1:0] op, int to, logic sd, logic cd, logic ok,
                              int wd, int poke, int sel, int lat, logic [1:0] code);
    vec_t v;
    v.op = op; v.to = to; v.set_done = sd; v.chk_done = cd; v.chk_ok = ok;
    v.wd_at = wd; v.poke_at = poke; v.exp_sel = sel; v.exp_lat = lat; v.code = code;
    return v;
  endfunction

  task automatic push_exp(input logic [1:0] c);
    exp_t e;
`ifdef CMD_DECODER_ERR_STICKY_EN
    if (c != 2'd0 && !sticky_err) begin
      sticky_err  = 1'b1;
      sticky_code = c;
    end
    e.err  = sticky_err;
    e.code = sticky_code;
`else
    e.err  = (c != 2'd0);
    e.code = c;
`endif
    sb.push_back(e);
    last_e = e;
  endtask

  task automatic model_reset();
    sticky_err  = 1'b0;
    sticky_code = 2'd0;
    last_e      = '0;
    exp_cnt     = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_ack) begin
      if (sb.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_err", 32'(bus.o_err), 32'(e.err));
        chk("ack_code", 32'(bus.o_err_code), 32'(e.code));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc, nsel, wcnt;
    logic seen, busy_ok, edge_ok;
    @(posedge clk); #1;
    bus.i_args[0]    = v.op;
    bus.i_timeout    = TO_W'(v.to);
    bus.i_args_valid = 1'b1;
    bus.i_set_done   = v.set_done;
    bus.i_check_done = v.chk_done;
    bus.i_check_ok   = v.chk_ok;
    bus.i_wait_done  = 1'b0;
    push_exp(v.code);
    @(posedge clk); #1;
    bus.i_args_valid = 1'b0;
    cyc = 0; nsel = 0; wcnt = 0; seen = 1'b0; busy_ok = 1'b1; edge_ok = 1'b1;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.o_ack) seen = 1'b1;
      else begin
        if (!bus.o_busy) busy_ok = 1'b0;
        if (bus.o_sel_set || bus.o_sel_wait || bus.o_sel_check) nsel++;
        if (bus.o_sel_wait) begin
          if (bus.o_wait_edge !== (v.op == OP_WTF)) edge_ok = 1'b0;
          bus.i_wait_done  = (v.wd_at >= 0 && wcnt >= v.wd_at);
          bus.i_args_valid = (wcnt == v.poke_at);
          wcnt++;
        end else bus.i_args_valid = 1'b0;
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'(v.exp_lat));
    chk("sel_cycles", 32'(nsel), 32'(v.exp_sel));
    chk("busy_held", 32'(busy_ok), 32'd1);
    chk("wait_edge", 32'(edge_ok), 32'd1);
    exp_cnt++;
    @(negedge clk);
    chk("ack_one_cycle", 32'(bus.o_ack), 32'd0);
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
    chk("cmd_cnt", 32'(bus.o_cmd_cnt), 32'(CNT_W'(exp_cnt)));
    chk("code_hold", 32'(bus.o_err_code), 32'(last_e.code));
`ifdef CMD_DECODER_ERR_STICKY_EN
    chk("err_after", 32'(bus.o_err), 32'(last_e.err));
`else
    chk("err_after", 32'(bus.o_err), 32'd0);
`endif
    bus.i_args_valid = 1'b0;
    bus.i_set_done   = 1'b0;
    bus.i_wait_done  = 1'b0;
    bus.i_check_done = 1'b0;
    bus.i_check_ok   = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_sel"}, 32'({bus.o_sel_set, bus.o_sel_wait, bus.o_sel_check}), 32'd0);
    chk({tag, "_edge"}, 32'(bus.o_wait_edge), 32'd0);
    chk({tag, "_ack"}, 32'(bus.o_ack), 32'd0);
    chk({tag, "_err"}, 32'(bus.o_err), 32'd0);
    chk({tag, "_code"}, 32'(bus.o_err_code), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.o_cmd_cnt), 32'd0);
    chk({tag, "_cnt2"}, 32'(bus2.o_cmd_cnt), 32'd0);
  endtask

  initial begin
    bus.i_args       = '0;
    bus.i_args_valid = 1'b0;
    bus.i_timeout    = '0;
    bus.i_set_done   = 1'b0;
    bus.i_wait_done  = 1'b0;
    bus.i_check_done = 1'b0;
    bus.i_check_ok   = 1'b0;
    model_reset();

    //          op      to  sd  cd  ok   wd  poke sel lat code
    tbl[0] = mk(OP_SET, 0,  1,  0,  0,  -1, -1,  1,  3, 2'd0);
    tbl[1] = mk(OP_WTF, 0,  0,  0,  0,  50, -1, 51, 53, 2'd0);
    tbl[2] = mk(OP_WTR, 10, 0,  0,  0,  -1, -1, 10, 12, 2'd2);
    tbl[3] = mk(OP_WTR, 10, 0,  0,  0,   9, -1, 10, 12, 2'd0);
    tbl[4] = mk(OP_CHK, 0,  0,  1,  0,  -1, -1,  1,  3, 2'd3);
    tbl[5] = mk(OP_CHK, 0,  0,  1,  1,  -1, -1,  1,  3, 2'd0);
    tbl[6] = mk(OP_XYZ, 0,  1,  1,  1,  -1, -1,  0,  2, 2'd1);
    tbl[7] = mk(OP_WTR, 0,  0,  0,  0,  20,  5, 21, 23, 2'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Abort a WAIT with a one-cycle reset: no ack, counters cleared.
    @(posedge clk); #1;
    bus.i_args[0]    = OP_WTR;
    bus.i_timeout    = '0;
    bus.i_args_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_args_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_wait", 32'(bus.o_sel_wait), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_cleared("abort");
    begin
      logic stray;
      stray = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (bus.o_ack || bus.o_busy) stray = 1'b1;
      end
      chk("abort_quiet", 32'(stray), 32'd0);
    end

    // Five commands: 16-bit counter reads 5, the 2-bit twin wraps to 1.
    repeat (5) run_vec(tbl[0]);
    chk("cnt_wrap", 32'(bus2.o_cmd_cnt), 32'd1);
    chk("cnt_full", 32'(bus.o_cmd_cnt), 32'd5);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cmd_decoder_fsm.md
Name: cmd_decoder_fsm

Overview:
Sequential successor of the testbench command decoder. It accepts one scenario command as a string argument array and dispatches it to the SET, WAIT or CHECK sub-block. It tracks completion, with a per-command timeout on waits, and returns a single-cycle acknowledge with error status to the scenario reader. It sits between the scenario file reader and the SET/WAIT/CHECK testbench blocks.

Parameters:
ARGS_NB, 5, number of string arguments per command line (i_args[0] is the opcode).
TO_WIDTH, 16, width of the timeout value and of the wait cycle counter.
CNT_WIDTH, 16, width of the executed-command counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
i_args  input  string[ARGS_NB]  command arguments; i_args[0] is the opcode.
i_args_valid  input  1  command present; sampled only in IDLE.
i_timeout  input  TO_WIDTH  wait timeout in clk cycles, latched with the command; 0 means no timeout.
o_busy  output  1  high whenever state is not IDLE.
o_sel_set  output  1  SET sub-block select.
i_set_done  input  1  SET sub-block finished.
o_sel_wait  output  1  WAIT sub-block select.
o_wait_edge  output  1  0 = WTR (rising), 1 = WTF (falling); valid while o_sel_wait is high.
i_wait_done  input  1  WAIT condition met.
o_sel_check  output  1  CHECK sub-block select.
i_check_done  input  1  CHECK result valid.
i_check_ok  input  1  CHECK passed; qualified by i_check_done.
o_ack  output  1  one-cycle command-complete pulse.
o_err  output  1  error indication (see Optional Feature).
o_err_code  output  2  0 none, 1 unknown opcode, 2 wait timeout, 3 check fail.
o_cmd_cnt  output  CNT_WIDTH  number of commands completed, whether acked or errored.

Behaviour:
- Reset (rst_n=0 at a clk edge): state goes to IDLE. o_busy, all o_sel_*, o_wait_edge, o_ack and o_err are 0. o_err_code and o_cmd_cnt are 0. The wait counter is 0.
- Reset asserted mid-command aborts the command. No ack is issued. The state is IDLE on the next cycle.
- States: IDLE, DECODE, SET, WAIT, CHECK, ACK, ERR. Outputs are Moore-decoded from the registered state.
- IDLE: when i_args_valid=1, latch i_args[0] and i_timeout, go to DECODE, and clear o_err_code to 0 (non-sticky build). i_args_valid while busy is ignored and is not queued.
- DECODE (1 cycle), next state by latched opcode:
  - "SET" -> SET.
  - "WTR" -> WAIT with edge=0.
  - "WTF" -> WAIT with edge=1.
  - "CHK" -> CHECK.
  - Any other opcode -> ERR with code 1.
- SET: o_sel_set=1. Go to ACK on the first cycle i_set_done=1.
- WAIT: o_sel_wait=1 and o_wait_edge holds the latched edge.
  - The counter starts at 0 on entry and increments by 1 each cycle in WAIT.
  - i_wait_done=1 -> ACK.
  - Latched timeout is nonzero and counter == timeout-1 with no done -> ERR with code 2, so the timeout fires after exactly `timeout` cycles in WAIT.
  - Done and timeout in the same cycle: done wins, go to ACK.
  - Latched timeout 0: wait forever.
- CHECK: o_sel_check=1. When i_check_done=1: i_check_ok=1 -> ACK, otherwise ERR with code 3.
- ACK (1 cycle): o_ack=1, o_cmd_cnt increments, then IDLE.
- ERR (1 cycle): o_ack=1, o_err=1, o_cmd_cnt increments, o_err_code loaded, then IDLE.
- o_cmd_cnt wraps modulo 2^CNT_WIDTH.
- Latency, with valid sampled at edge N:
  - DECODE at N+1.
  - sel high at N+2.
  - A done sampled at edge M gives o_ack high in cycle M+1.
  - Minimum command-to-ack is 3 cycles (done already high on sel entry).
  - Unknown opcode gives ack at N+2.
- A new command can be accepted on the edge that ends the ACK/ERR cycle's successor IDLE cycle. Back-to-back throughput is one command per 4 cycles minimum.
- o_err_code holds its value through IDLE until the next command is accepted.

Optional Feature:
CMD_DECODER_ERR_STICKY_EN.
- Defined: o_err is set on the first ERR entry and stays 1 until reset. o_err_code keeps the first error's code and is not cleared on new commands or overwritten by later errors. Later errors still pulse o_ack and count.
- Undefined: o_err is a one-cycle pulse coincident with o_ack in ERR. o_err_code clears on each accepted command.

Test Plan:
1. Reset then "SET" with i_set_done held 1 -> o_sel_set high for 1 cycle, o_ack pulse 3 cycles after valid, o_cmd_cnt=1, o_err=0.
2. "WTF" with i_timeout=0, i_wait_done raised after 50 cycles in WAIT -> o_wait_edge=1 throughout, o_ack one cycle after done, o_err_code=0.
3. "WTR" with i_timeout=10 and no done -> exactly 10 cycles of o_sel_wait, then o_ack=1 and o_err=1 together, o_err_code=2. A repeat with done in the 10th cycle gives ack with no error.
4. "CHK" with i_check_done=1 and i_check_ok=0 -> ERR code 3. The next "CHK" with ok=1 -> code cleared to 0 (non-sticky), or code held at 3 with o_err still 1 (sticky build).
5. Opcode "XYZ" -> o_ack and o_err at valid+2, code 1, no sel asserted. i_args_valid pulsed during a busy WAIT -> ignored, o_cmd_cnt rises by 1 only.
6. rst_n=0 for 1 cycle mid-WAIT -> next cycle IDLE, all outputs 0, o_cmd_cnt=0, no ack. With CNT_WIDTH=2, 5 commands -> o_cmd_cnt=1 (wrap).
